// File: rtl/unet_out_packer.sv
// unet_out_packer: packs two UNET samples per 32-bit stream word.
// Optional frame checksum word when UNET_OUT_CHECKSUM_EN is defined.
module unet_out_packer #(
  parameter int pDATA_WIDTH    = 32,
  parameter int pSAMPLE_WIDTH  = 12,
  parameter int pFRAME_SAMPLES = 12288
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  input  logic                     clear,
  input  logic [pSAMPLE_WIDTH-1:0] in_dat,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic                     sm_tvalid,
  output logic [pDATA_WIDTH-1:0]   sm_tdata,
  output logic [3:0]               sm_tstrb,
  output logic [3:0]               sm_tkeep,
  output logic                     sm_tlast,
  input  logic                     sm_tready,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int NW  = pFRAME_SAMPLES / 2;
  localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(NW - 1);

`ifdef UNET_OUT_CHECKSUM_EN
  typedef enum logic [1:0] {S_LO, S_HI, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_LO, S_HI} state_t;
`endif

  state_t                   state_q, state_d;
  logic [pSAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic [WCW-1:0]           wcnt_q, wcnt_d;
  logic [pDATA_WIDTH-1:0]   mem_q [2];
  logic [1:0]               last_q;
  logic                     wptr_q, rptr_q;
  logic [1:0]               cnt_q, cnt_d;
  logic                     fd_q, fd_d;
  logic                     busy_q, busy_d;
  logic                     in_hs, pop, push, push_last;
  logic                     head_last, frame_start, more_pending;
  logic [pDATA_WIDTH-1:0]   pack, push_data;
`ifdef UNET_OUT_CHECKSUM_EN
  logic [31:0]              acc_q, acc_d;
`endif

  // Ready is a function of state and occupancy only, never of in_vld.
  always_comb begin
    in_rdy = 1'b0;
    unique case (state_q)
      S_LO:    in_rdy = 1'b1;
      S_HI:    in_rdy = (cnt_q < 2'd2);
      default: in_rdy = 1'b0;
    endcase
  end

  assign in_hs     = in_vld & in_rdy;
  assign head_last = last_q[rptr_q];
  assign sm_tvalid = (cnt_q != 2'd0);
  assign sm_tdata  = sm_tvalid ? mem_q[rptr_q] : '0;
  assign sm_tlast  = sm_tvalid & head_last;
  assign sm_tstrb  = {4{sm_tvalid}};
  assign sm_tkeep  = {4{sm_tvalid}};
  assign pop       = sm_tvalid & sm_tready;
  assign frame_done = fd_q;
  assign busy       = busy_q;

  // Word layout: held sample in the low half, current sample in the high half.
  always_comb begin
    pack = '0;
    pack[pSAMPLE_WIDTH-1:0]   = hold_q;
    pack[16 +: pSAMPLE_WIDTH] = in_dat;
  end

  // Packing FSM: next state, word counter and FIFO push request.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wcnt_d    = wcnt_q;
    push      = 1'b0;
    push_last = 1'b0;
    push_data = pack;
`ifdef UNET_OUT_CHECKSUM_EN
    acc_d     = acc_q;
`endif
    unique case (state_q)
      S_LO: begin
        if (in_hs) begin
          hold_d  = in_dat;
          state_d = S_HI;
`ifdef UNET_OUT_CHECKSUM_EN
          acc_d   = acc_q + 32'(in_dat);
`endif
        end
      end
      S_HI: begin
        if (in_hs) begin
          push = 1'b1;
`ifdef UNET_OUT_CHECKSUM_EN
          acc_d = acc_q + 32'(in_dat);
`endif
          if (wcnt_q == WLAST) begin
            wcnt_d = '0;
`ifdef UNET_OUT_CHECKSUM_EN
            state_d = S_CSUM;
`else
            push_last = 1'b1;
            state_d   = S_LO;
`endif
          end else begin
            wcnt_d  = wcnt_q + WCW'(1);
            state_d = S_LO;
          end
        end
      end
`ifdef UNET_OUT_CHECKSUM_EN
      S_CSUM: begin
        if (cnt_q < 2'd2) begin
          push      = 1'b1;
          push_data = acc_q;
          push_last = 1'b1;
          acc_d     = '0;
          state_d   = S_LO;
        end
      end
`endif
      default: state_d = S_LO;
    endcase
  end

  // Occupancy, frame tracking and the done pulse.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    frame_start  = in_hs && (state_q == S_LO) && (wcnt_q == '0);
    more_pending = (state_q != S_LO) || (wcnt_q != '0) ||
                   (cnt_q == 2'd2);
    fd_d   = pop & head_last;
    busy_d = busy_q;
    if (frame_start)
      busy_d = 1'b1;
    else if (pop && head_last)
      busy_d = more_pending;
  end

  // Control registers; clear wins over everything.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q <= S_LO;
      hold_q  <= '0;
      wcnt_q  <= '0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UNET_OUT_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else if (clear) begin
      state_q <= S_LO;
      hold_q  <= '0;
      wcnt_q  <= '0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UNET_OUT_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wcnt_q  <= wcnt_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
`ifdef UNET_OUT_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Two-entry output FIFO; simultaneous push and pop keep order.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      last_q   <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clear) begin
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wptr_q]  <= push_data;
        last_q[wptr_q] <= push_last;
        wptr_q         <= ~wptr_q;
      end
      if (pop)
        rptr_q <= ~rptr_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_unet_out_packer.sv
// tb_unet_out_packer: vector table, directed corners and random
// traffic against a queue-based model of the packer.
module tb_unet_out_packer;

  localparam int FS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [11:0] in_dat;
  logic        in_vld;
  logic        in_rdy;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic [3:0]  sm_tstrb;
  logic [3:0]  sm_tkeep;
  logic        sm_tlast;
  logic        sm_tready;
  logic        frame_done;
  logic        busy;

  always #5 clk = ~clk;

  unet_out_packer #(
    .pDATA_WIDTH(32),
    .pSAMPLE_WIDTH(12),
    .pFRAME_SAMPLES(FS)
  ) dut (
    .axi_clk(clk),
    .axi_reset_n(rst_n),
    .clear(clear),
    .in_dat(in_dat),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .sm_tvalid(sm_tvalid),
    .sm_tdata(sm_tdata),
    .sm_tstrb(sm_tstrb),
    .sm_tkeep(sm_tkeep),
    .sm_tlast(sm_tlast),
    .sm_tready(sm_tready),
    .frame_done(frame_done),
    .busy(busy)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: samples pair up into words; every FS/2-th word
  // of a frame is last; clear drops everything in flight.
  logic [31:0] mq[$];
  bit          lq[$];
  logic [31:0] obs[$];
  logic [11:0] pend;
  int          sidx = 0;
  bit          fd_exp = 1'b0;
  int          nfd = 0;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      lq.delete();
      sidx = 0;
      fd_exp = 1'b0;
    end else if (mon_en) begin
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      if (frame_done) nfd++;
      chk("tvalid", 32'(sm_tvalid), 32'(mq.size() != 0));
      chk("in_rdy", 32'(in_rdy),
          32'(!((sidx % 2 == 1) && (mq.size() >= 2))));
      fd_exp = 1'b0;
      if (sm_tvalid && mq.size() != 0) begin
        chk("tdata", sm_tdata, mq[0]);
        chk("tlast", 32'(sm_tlast), 32'(lq[0]));
        chk("tstrb", 32'(sm_tstrb), 32'h0000000F);
        chk("tkeep", 32'(sm_tkeep), 32'h0000000F);
      end
      if (sm_tvalid && sm_tready) begin
        obs.push_back(sm_tdata);
        if (mq.size() != 0) begin
          fd_exp = lq[0] && !clear;
          void'(mq.pop_front());
          void'(lq.pop_front());
        end
      end
      if (in_vld && in_rdy && !clear) begin
        if (sidx % 2 == 0) begin
          pend = in_dat;
        end else begin
          mq.push_back({4'h0, in_dat, 4'h0, pend});
          lq.push_back(sidx == FS - 1);
        end
        sidx = (sidx + 1) % FS;
      end
      if (clear) begin
        mq.delete();
        lq.delete();
        sidx = 0;
      end
    end
  end

  typedef struct {
    logic        vld;
    logic [11:0] dat;
    logic        e_rdy;
    logic        e_tv;
    logic [31:0] e_td;
    logic        e_tl;
    logic        e_busy;
    logic        e_fd;
  } vec_t;

  vec_t tbl[11];

  task automatic send(input logic [11:0] d);
    bit ok;
    ok = 1'b0;
    in_vld = 1'b1;
    in_dat = d;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (in_rdy) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout: sample %h not accepted", d);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (mq.size() == 0 && !sm_tvalid) ok = 1'b1;
    end
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL drain_timeout: words left %0d", mq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int  nfd0;
  bit  done;
  bit  hs;

  initial begin
    tbl[0]  = '{1'b1, 12'h001, 1, 0, 32'h0,        0, 0, 0};
    tbl[1]  = '{1'b1, 12'h002, 1, 0, 32'h0,        0, 1, 0};
    tbl[2]  = '{1'b1, 12'h003, 1, 1, 32'h00020001, 0, 1, 0};
    tbl[3]  = '{1'b1, 12'h004, 1, 0, 32'h0,        0, 1, 0};
    tbl[4]  = '{1'b1, 12'h005, 1, 1, 32'h00040003, 0, 1, 0};
    tbl[5]  = '{1'b1, 12'h006, 1, 0, 32'h0,        0, 1, 0};
    tbl[6]  = '{1'b1, 12'h007, 1, 1, 32'h00060005, 0, 1, 0};
    tbl[7]  = '{1'b1, 12'h008, 1, 0, 32'h0,        0, 1, 0};
    tbl[8]  = '{1'b0, 12'h000, 1, 1, 32'h00080007, 1, 1, 0};
    tbl[9]  = '{1'b0, 12'h000, 1, 0, 32'h0,        0, 0, 1};
    tbl[10] = '{1'b0, 12'h000, 1, 0, 32'h0,        0, 0, 0};

    rst_n = 1'b0;
    clear = 1'b0;
    in_vld = 1'b0;
    in_dat = '0;
    sm_tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_tvalid", 32'(sm_tvalid), 32'd0);
    chk("rst_tdata", sm_tdata, 32'd0);
    chk("rst_tlast", 32'(sm_tlast), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Full-rate frame, cycle by cycle.
    for (int i = 0; i < 11; i++) begin
      in_vld = tbl[i].vld;
      in_dat = tbl[i].dat;
      @(negedge clk);
      chk($sformatf("tbl%0d_rdy", i), 32'(in_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_tv", i), 32'(sm_tvalid), 32'(tbl[i].e_tv));
      chk($sformatf("tbl%0d_td", i), sm_tdata, tbl[i].e_td);
      chk($sformatf("tbl%0d_tl", i), 32'(sm_tlast), 32'(tbl[i].e_tl));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_fd", i), 32'(frame_done), 32'(tbl[i].e_fd));
      @(posedge clk);
      #1;
    end

    // Stalled sink: FIFO fills, sixth sample must wait.
    obs.delete();
    sm_tready = 1'b0;
    for (int s = 1; s <= 5; s++) send(12'(s));
    in_dat = 12'h006;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_rdy", 32'(in_rdy), 32'd0);
      chk("stall_head", sm_tdata, 32'h00020001);
      @(posedge clk);
      #1;
    end
    sm_tready = 1'b1;
    for (int s = 6; s <= 8; s++) send(12'(s));
    in_vld = 1'b0;
    drain();
    chk("stall_words", 32'(obs.size()), 32'd4);
    if (obs.size() == 4) begin
      chk("stall_w0", obs[0], 32'h00020001);
      chk("stall_w3", obs[3], 32'h00080007);
    end

    // Two back-to-back frames, random sink backpressure.
    obs.delete();
    nfd0 = nfd;
    done = 1'b0;
    fork
      begin
        for (int s = 0; s < 2 * FS; s++) send(12'($urandom_range(0, 4095)));
        in_vld = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          sm_tready = 1'($urandom % 2);
        end
      end
    join
    sm_tready = 1'b1;
    drain();
    chk("b2b_words", 32'(obs.size()), 32'd8);
    chk("b2b_frame_done", 32'(nfd - nfd0), 32'd2);

    // Abort mid-frame, then a clean frame.
    send(12'h031);
    send(12'h032);
    send(12'h033);
    in_dat = 12'h034;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_vld = 1'b0;
    @(negedge clk);
    chk("clr_tvalid", 32'(sm_tvalid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_in_rdy", 32'(in_rdy), 32'd1);
    chk("clr_fd", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    obs.delete();
    nfd0 = nfd;
    for (int s = 8'h11; s <= 8'h18; s++) send(12'(s));
    in_vld = 1'b0;
    drain();
    chk("clr_words", 32'(obs.size()), 32'd4);
    if (obs.size() != 0) chk("clr_first", obs[0], 32'h00120011);
    chk("clr_frame_done", 32'(nfd - nfd0), 32'd1);

    // Random traffic with occasional aborts.
    in_vld = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = in_vld && in_rdy;
      @(posedge clk);
      #1;
      if (hs || !in_vld) begin
        in_vld = ($urandom % 4) != 0;
        in_dat = 12'($urandom);
      end
      sm_tready = 1'($urandom % 2);
      clear = ($urandom % 100) == 0;
    end
    in_vld = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    sm_tready = 1'b1;
    @(negedge clk);
    chk("end_tvalid", 32'(sm_tvalid), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/unet_out_packer.md
Name: unet_out_packer

Overview:
Downstream stage of the UNET user project. It consumes the 12-bit sample stream from the UNET IP output interface (dat/vld/rdy) and packs two samples per 32-bit AXI-Stream word on the sm_* master port. It marks frame boundaries with sm_tlast and buffers two words so the IP is never stalled while the stream master accepts every cycle. It replaces the direct zero-extend wiring of output_rsc_dat onto sm_tdata, halving stream-side beats per frame.

Parameters:
pDATA_WIDTH, 32, stream word width; fixed at 32.
pSAMPLE_WIDTH, 12, sample width; legal range 1..16.
pFRAME_SAMPLES, 12288, samples per frame (64*64*3); must be even and >= 2.

Ports:
axi_clk  input  1  block clock; all logic is on the rising edge.
axi_reset_n  input  1  asynchronous, active-low reset.
clear  input  1  synchronous active-high abort; driven high while the user project is in S_IDLE.
in_dat  input  pSAMPLE_WIDTH  sample from the UNET IP.
in_vld  input  1  sample valid.
in_rdy  output  1  sample ready.
sm_tvalid  output  1  stream word valid.
sm_tdata  output  32  packed word.
sm_tstrb  output  4  byte strobes.
sm_tkeep  output  4  byte keeps.
sm_tlast  output  1  last word of frame.
sm_tready  input  1  stream word ready.
frame_done  output  1  one-cycle pulse when the last word of a frame is accepted.
busy  output  1  high from the first accepted sample of a frame until its last word handshake.

Behaviour:
- Clock and reset: one clock, axi_clk. Reset is asynchronous and active-low, axi_reset_n.
- Reset values:
  - in_rdy = 1
  - sm_tvalid = 0, sm_tdata = 0, sm_tlast = 0
  - frame_done = 0, busy = 0
  - FIFO empty, sample and word counters = 0, state = S_LO
- Handshakes: a transfer occurs when valid && ready. Once valid is asserted, it and its data hold until accepted. Ready never depends combinationally on valid.
- Packing state machine:
  - S_LO: the incoming sample is stored in the hold register. in_rdy = 1. On handshake, go to S_HI.
  - S_HI: in_rdy = (fifo_count < 2). On handshake, push the word {4'h0, in_dat, 4'h0, hold} (pSAMPLE_WIDTH=12: sample0 in bits [11:0], sample1 in bits [27:16], unused bits 0), tagged last = (word_cnt == pFRAME_SAMPLES/2 - 1), then go to S_LO.
  - S_CSUM: exists only with the optional feature; see below.
- Word counter:
  - Increments on every word pushed.
  - Wraps to 0 after the last word of a frame; back-to-back frames need no gap.
- Output FIFO:
  - 2 entries; sm_tdata and sm_tlast are driven from the head entry.
  - sm_tvalid = (count != 0).
  - A push and a pop in the same cycle are legal at any count: count is unchanged and order is preserved.
  - Full (count == 2) blocks only the S_HI handshake.
- sm_tstrb and sm_tkeep = 4'hF whenever sm_tvalid = 1, else 0.
- Latency:
  - The first word becomes valid 1 cycle after the second sample's handshake.
  - Sustained throughput is 1 sample/cycle in and 1 word per 2 cycles out.
- frame_done: registered pulse, asserted the cycle after the sm handshake of the word tagged last.
- busy:
  - Set on the first sample handshake of a frame.
  - Cleared together with the frame_done assertion.
- clear (synchronous, highest priority):
  - Next cycle: state = S_LO, FIFO empty, counters = 0, sm_tvalid = 0, busy = 0, and no frame_done pulse.
  - Any partial frame is discarded.
  - Input handshakes in the clear cycle are ignored.
- Reset mid-frame: identical outcome to clear, applied asynchronously.

Optional Feature:
Macro UNET_OUT_CHECKSUM_EN.
- Defined:
  - A 32-bit accumulator sums zero-extended samples modulo 2^32 over the frame.
  - After the last data word is pushed, go to S_CSUM with in_rdy = 0. When fifo_count < 2, push the accumulator value (including the frame's final sample) as an extra word tagged last, then go to S_LO and clear the accumulator.
  - The last data word is no longer tagged last.
  - frame_done and busy key off the checksum word.
- Undefined: no accumulator, no S_CSUM state; frames are exactly pFRAME_SAMPLES/2 words.

Test Plan:
- Reset then idle (pFRAME_SAMPLES=8) -> in_rdy=1, sm_tvalid=0, busy=0.
- Samples 0x001..0x008 with in_vld held high and sm_tready=1 -> 4 words:
  - 0x00020001, 0x00040003, 0x00060005, 0x00080007
  - tlast only on the 4th word; frame_done pulses once; no in_rdy deassertion.
- Same frame with sm_tready=0 -> after 2 words are buffered, in_rdy drops in S_HI on the 6th sample. Raising sm_tready releases the words in order with no loss or duplication.
- Two back-to-back frames with random sm_tready -> 8 words total, tlast on words 4 and 8, two frame_done pulses.
- clear asserted after 3 samples, then a fresh frame of 0x011..0x018 -> the first output word is 0x00120011 and the frame is complete with correct tlast.
- With UNET_OUT_CHECKSUM_EN, samples 0x001..0x008 -> 5 words; the 5th is 0x00000024 with tlast=1; the 4th word has tlast=0.
